// File: rtl/sma_pkg.sv
// rtl/sma_pkg.sv - shared types and helpers for the SMA level detector
package sma_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_PEND = 2'd1,
    HIGH      = 2'd2,
    FALL_PEND = 2'd3
  } sma_lvl_state_t;

  // Increment that sticks at limit; callers cast the result to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
    return (value >= limit) ? limit : value + 32'd1;
  endfunction

endpackage

// File: rtl/sma_episode_stats.sv
// rtl/sma_episode_stats.sv - peak and dwell tracker for one high episode
module sma_episode_stats
  import sma_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   open,
  input  logic                   update,
  input  logic                   discard,
  input  logic                   close,
  input  logic [DATA_WIDTH-1:0]  sample,
  output logic [DATA_WIDTH-1:0]  peak_value,
  output logic [DWELL_WIDTH-1:0] dwell_len
);

  localparam logic [DWELL_WIDTH-1:0] DWELL_ONES = '1;
  localparam logic [31:0]            DWELL_MAX  = 32'(DWELL_ONES);

  logic [DATA_WIDTH-1:0]  peak, peak_next;
  logic [DWELL_WIDTH-1:0] dwell, dwell_next;

  // Totals including the current sample, so close captures the final debounce sample.
  always_comb begin
    peak_next  = (sample > peak) ? sample : peak;
    dwell_next = DWELL_WIDTH'(sat_inc(32'(dwell), DWELL_MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak       <= '0;
      dwell      <= '0;
      peak_value <= '0;
      dwell_len  <= '0;
    end else if (open) begin
      peak  <= sample;
      dwell <= DWELL_WIDTH'(1);
    end else if (discard) begin
      peak  <= '0;
      dwell <= '0;
    end else if (close) begin
      peak_value <= peak_next;
      dwell_len  <= dwell_next;
      peak       <= '0;
      dwell      <= '0;
    end else if (update) begin
      peak  <= peak_next;
      dwell <= dwell_next;
    end
  end

endmodule

// File: rtl/sma_level_detector.sv
// rtl/sma_level_detector.sv - debounced hysteresis level detector on the SMA output stream
module sma_level_detector
  import sma_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int DEBOUNCE_N  = 4,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_data_valid,
  input  logic                   cfg_enable,
  input  logic [DATA_WIDTH-1:0]  cfg_thresh_hi,
  input  logic [DATA_WIDTH-1:0]  cfg_thresh_lo,
  output logic                   level_high,
  output logic                   event_rise,
  output logic                   event_fall,
  output logic [DATA_WIDTH-1:0]  event_data,
  output logic [DATA_WIDTH-1:0]  peak_value,
  output logic [DWELL_WIDTH-1:0] dwell_len,
  output logic                   cfg_err
);

  localparam int              CW       = $clog2(DEBOUNCE_N + 1);
  localparam logic [CW-1:0]   CNT_DONE = CW'(DEBOUNCE_N);
  localparam logic [31:0]     CNT_MAX  = 32'(DEBOUNCE_N);

  sma_lvl_state_t state, state_next;
  logic [CW-1:0]  cnt, cnt_next, cnt_inc;
  logic           smp, above, below;
  logic           go_rise, go_fall;
  logic           st_open, st_update, st_discard, st_close;

  // A bad threshold pair freezes evaluation through the registered flag.
  assign smp     = in_data_valid & cfg_enable & ~cfg_err;
  assign above   = (in_data >= cfg_thresh_hi);
  assign below   = (in_data <= cfg_thresh_lo);
  assign cnt_inc = CW'(sat_inc(32'(cnt), CNT_MAX));

  always_ff @(posedge clk) begin
    if (rst || !cfg_enable) begin
      state <= LOW;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (smp) begin
      case (state)
        LOW: begin
          if (above) begin
            if (DEBOUNCE_N == 1) begin
              state_next = HIGH;
              cnt_next   = '0;
            end else begin
              state_next = RISE_PEND;
              cnt_next   = CW'(1);
            end
          end
        end
        RISE_PEND: begin
          if (!above) begin
            state_next = LOW;
            cnt_next   = '0;
          end else if (cnt_inc == CNT_DONE) begin
            state_next = HIGH;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        HIGH: begin
          if (below) begin
            if (DEBOUNCE_N == 1) begin
              state_next = LOW;
              cnt_next   = '0;
            end else begin
              state_next = FALL_PEND;
              cnt_next   = CW'(1);
            end
          end
        end
        FALL_PEND: begin
          if (!below) begin
            state_next = HIGH;
            cnt_next   = '0;
          end else if (cnt_inc == CNT_DONE) begin
            state_next = LOW;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = LOW;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    go_rise    = (state == LOW || state == RISE_PEND) && (state_next == HIGH);
    go_fall    = (state == HIGH || state == FALL_PEND) && (state_next == LOW);
    st_open    = smp && (state == LOW) && above;
    st_update  = smp && (state != LOW);
    st_discard = !cfg_enable || ((state == RISE_PEND) && (state_next == LOW));
    st_close   = go_fall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_high <= 1'b0;
      event_rise <= 1'b0;
      event_fall <= 1'b0;
      event_data <= '0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= (cfg_thresh_lo >= cfg_thresh_hi);
      if (!cfg_enable) begin
        level_high <= 1'b0;
        event_rise <= 1'b0;
        event_fall <= 1'b0;
      end else begin
        level_high <= (state_next == HIGH) || (state_next == FALL_PEND);
        event_rise <= go_rise;
        event_fall <= go_fall;
        if (go_rise || go_fall) event_data <= in_data;
      end
    end
  end

  sma_episode_stats #(
    .DATA_WIDTH (DATA_WIDTH),
    .DWELL_WIDTH(DWELL_WIDTH)
  ) u_stats (
    .clk       (clk),
    .rst       (rst),
    .open      (st_open),
    .update    (st_update),
    .discard   (st_discard),
    .close     (st_close),
    .sample    (in_data),
    .peak_value(peak_value),
    .dwell_len (dwell_len)
  );

endmodule

// File: tb/tb_sma_level_detector.sv
// tb/tb_sma_level_detector.sv - directed table-driven bench for sma_level_detector
module tb_sma_level_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_data_valid;
  logic        cfg_enable;
  logic [15:0] cfg_thresh_hi;
  logic [15:0] cfg_thresh_lo;
  logic        level_high, event_rise, event_fall, cfg_err;
  logic [15:0] event_data, peak_value, dwell_len;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        lvl;
    logic        rise;
    logic        fall;
    logic [15:0] ed;
    logic [15:0] pk;
    logic [15:0] dw;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  sma_level_detector #(
    .DATA_WIDTH (16),
    .DEBOUNCE_N (4),
    .DWELL_WIDTH(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_data_valid(in_data_valid),
    .cfg_enable   (cfg_enable),
    .cfg_thresh_hi(cfg_thresh_hi),
    .cfg_thresh_lo(cfg_thresh_lo),
    .level_high   (level_high),
    .event_rise   (event_rise),
    .event_fall   (event_fall),
    .event_data   (event_data),
    .peak_value   (peak_value),
    .dwell_len    (dwell_len),
    .cfg_err      (cfg_err)
  );

  function automatic void add(input logic v, input int d, input logic l, input logic r,
                              input logic f, input int ed, input int pk, input int dw);
    vec_t e;
    e.valid = v; e.data = 16'(d); e.lvl = l; e.rise = r; e.fall = f;
    e.ed = 16'(ed); e.pk = 16'(pk); e.dw = 16'(dw);
    tbl.push_back(e);
  endfunction

  task automatic compare(input string tag, input logic l, input logic r, input logic f,
                         input logic [15:0] ed, input logic [15:0] pk, input logic [15:0] dw);
    n_vec++;
    if ({level_high, event_rise, event_fall, event_data, peak_value, dwell_len} !==
        {l, r, f, ed, pk, dw}) begin
      n_bad++;
      $display("FAIL %s: got lvl=%0b rise=%0b fall=%0b ed=%0d pk=%0d dw=%0d, want lvl=%0b rise=%0b fall=%0b ed=%0d pk=%0d dw=%0d",
               tag, level_high, event_rise, event_fall, event_data, peak_value, dwell_len,
               l, r, f, ed, pk, dw);
    end
  endtask

  task automatic check_err(input string tag, input logic want);
    n_vec++;
    if (cfg_err !== want) begin
      n_bad++;
      $display("FAIL %s: cfg_err got %0b want %0b", tag, cfg_err, want);
    end
  endtask

  // Drive one cycle of input, then sample the outputs just after the edge.
  task automatic step(input logic v, input int d);
    @(negedge clk);
    in_data_valid = v;
    in_data       = 16'(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_data_valid = 1'b0; cfg_enable = 1'b1;
    cfg_thresh_hi = 16'd1000; cfg_thresh_lo = 16'd800;
    repeat (2) @(posedge clk);
    #1;
    compare("reset", 0, 0, 0, 0, 0, 0);
    check_err("reset_cfg_err", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Aborted rise (999 is not above), then a sample that drops back to LOW.
    add(1, 1200, 0,0,0, 0,0,0); add(1, 1200, 0,0,0, 0,0,0); add(1, 1200, 0,0,0, 0,0,0);
    add(1,  999, 0,0,0, 0,0,0); add(1, 1200, 0,0,0, 0,0,0); add(1,  500, 0,0,0, 0,0,0);
    // Full episode.
    add(1, 1100, 0,0,0, 0,0,0); add(1, 1300, 0,0,0, 0,0,0); add(1, 1250, 0,0,0, 0,0,0);
    add(1, 1500, 1,1,0, 1500,0,0); add(1, 1400, 1,0,0, 1500,0,0);
    add(1,  700, 1,0,0, 1500,0,0); add(1,  700, 1,0,0, 1500,0,0); add(1, 700, 1,0,0, 1500,0,0);
    add(1,  700, 0,0,1, 700,1500,9);
    // Back-to-back: new episode opens on the very next sample.
    add(1, 1200, 0,0,0, 700,1500,9); add(1, 1200, 0,0,0, 700,1500,9); add(1, 1200, 0,0,0, 700,1500,9);
    add(1, 1200, 1,1,0, 1200,1500,9);
    add(1,  500, 1,0,0, 1200,1500,9); add(1,  500, 1,0,0, 1200,1500,9); add(1, 500, 1,0,0, 1200,1500,9);
    add(1,  500, 0,0,1, 500,1200,8);
    // Exact-threshold samples and an aborted fall (801 is not below).
    add(1, 1000, 0,0,0, 500,1200,8); add(1, 1000, 0,0,0, 500,1200,8); add(1, 1000, 0,0,0, 500,1200,8);
    add(1, 1000, 1,1,0, 1000,1200,8);
    add(1,  800, 1,0,0, 1000,1200,8); add(1,  800, 1,0,0, 1000,1200,8); add(1, 801, 1,0,0, 1000,1200,8);
    add(1,  800, 1,0,0, 1000,1200,8); add(1,  800, 1,0,0, 1000,1200,8); add(1, 800, 1,0,0, 1000,1200,8);
    add(1,  800, 0,0,1, 800,1000,11);
    // Same full episode with idle cycles carrying junk data.
    add(1, 1100, 0,0,0, 800,1000,11); add(0, 5000, 0,0,0, 800,1000,11);
    add(1, 1300, 0,0,0, 800,1000,11); add(0, 5000, 0,0,0, 800,1000,11); add(0, 5000, 0,0,0, 800,1000,11);
    add(1, 1250, 0,0,0, 800,1000,11); add(1, 1500, 1,1,0, 1500,1000,11);
    add(0,  100, 1,0,0, 1500,1000,11); add(0, 100, 1,0,0, 1500,1000,11); add(0, 100, 1,0,0, 1500,1000,11);
    add(1, 1400, 1,0,0, 1500,1000,11); add(0, 100, 1,0,0, 1500,1000,11);
    add(1,  700, 1,0,0, 1500,1000,11); add(1, 700, 1,0,0, 1500,1000,11);
    add(0, 5000, 1,0,0, 1500,1000,11); add(0, 5000, 1,0,0, 1500,1000,11);
    add(1,  700, 1,0,0, 1500,1000,11); add(1, 700, 0,0,1, 700,1500,9);
    add(0, 5000, 0,0,0, 700,1500,9);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].valid, int'(tbl[i].data));
      compare($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].rise, tbl[i].fall,
              tbl[i].ed, tbl[i].pk, tbl[i].dw);
    end

    // Drop enable while HIGH: level clears with no fall event.
    for (int i = 0; i < 4; i++) step(1, 1100);
    compare("dis_rise", 1, 1, 0, 1100, 1500, 9);
    @(negedge clk);
    cfg_enable = 1'b0;
    step(1, 700);
    compare("dis_drop", 0, 0, 0, 1100, 1500, 9);
    @(negedge clk);
    cfg_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1, 700);
      compare($sformatf("reen%0d", i), 0, 0, 0, 1100, 1500, 9);
    end

    // Bad thresholds freeze the detector.
    @(negedge clk);
    cfg_thresh_lo = 16'd1000;
    step(0, 0);
    check_err("err_set", 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1, 2000);
      compare($sformatf("err_frz%0d", i), 0, 0, 0, 1100, 1500, 9);
    end
    @(negedge clk);
    cfg_thresh_lo = 16'd800;
    step(0, 0);
    check_err("err_clr", 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1, 2000);
      compare($sformatf("post_err%0d", i), 0, 0, 0, 1100, 1500, 9);
    end
    step(1, 2000);
    compare("post_err_rise", 1, 1, 0, 2000, 1500, 9);

    // Reset mid-episode.
    step(1, 700);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    compare("mid_rst", 0, 0, 0, 0, 0, 0);
    check_err("mid_rst_err", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1, 700);
      compare($sformatf("after_rst%0d", i), 0, 0, 0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sma_level_detector.md
# sma_level_detector

Hysteresis level detector placed directly downstream of the simple-moving-average filter. It consumes the filter's smoothed output stream (data plus valid) and compares each sample against a high and a low threshold. A qualifying crossing must persist for a debounce count of consecutive valid samples before the block asserts a debounced level and emits one-cycle rise/fall events. Each completed high episode also reports its peak value and its length in samples.

## Interface
- DATA_WIDTH, 16: width of the smoothed sample; matches the filter's DATA_INPUT_WIDTH.
- DEBOUNCE_N, 4: consecutive qualifying valid samples required to change level; legal range ≥1.
- DWELL_WIDTH, 16: width of the episode-length counter; saturating.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  smoothed sample from the SMA filter, unsigned.
- in_data_valid  in  1  sample qualifier; one sample per asserted cycle, no backpressure.
- cfg_enable  in  1  detector enable.
- cfg_thresh_hi  in  DATA_WIDTH  rise threshold, unsigned.
- cfg_thresh_lo  in  DATA_WIDTH  fall threshold, unsigned; must be < cfg_thresh_hi.
- level_high  out  1  debounced level, registered.
- event_rise  out  1  one-cycle pulse on the LOW→HIGH transition.
- event_fall  out  1  one-cycle pulse on the HIGH→LOW transition.
- event_data  out  DATA_WIDTH  sample that completed the last transition; holds between events.
- peak_value  out  DATA_WIDTH  maximum sample of the completed episode; valid with event_fall; holds.
- dwell_len  out  DWELL_WIDTH  valid-sample count of the completed episode; valid with event_fall; holds.
- cfg_err  out  1  registered flag: cfg_thresh_lo ≥ cfg_thresh_hi.

## Operation
- Definitions: "above" means in_data ≥ cfg_thresh_hi; "below" means in_data ≤ cfg_thresh_lo.
- Qualification: only cycles with in_data_valid=1 are evaluated. Invalid cycles neither advance nor break the debounce.
- FSM states: LOW, RISE_PEND, HIGH, FALL_PEND. The debounce counter cnt is 0..DEBOUNCE_N.
- LOW:
  - above → cnt=1, go to RISE_PEND.
  - If DEBOUNCE_N=1, go straight to HIGH with event_rise instead.
  - Otherwise stay in LOW.
- RISE_PEND:
  - above → cnt+1; when cnt reaches DEBOUNCE_N → HIGH, event_rise.
  - Not above → LOW, cnt=0, no event; episode statistics are discarded.
- HIGH:
  - below → cnt=1, go to FALL_PEND.
  - If DEBOUNCE_N=1, go straight to LOW with event_fall instead.
- FALL_PEND:
  - below → cnt+1; when cnt reaches DEBOUNCE_N → LOW, event_fall.
  - Not below → HIGH, cnt=0.
- Episode statistics:
  - The episode opens on the first above sample taken in LOW. peak is initialised to that sample and dwell to 1.
  - Every later valid sample in RISE_PEND/HIGH/FALL_PEND updates peak=max(peak, in_data) and dwell+1, saturating at all-ones.
  - On event_fall, peak_value and dwell_len load the totals, including the final debounce sample.
- event_data loads the sample that triggered event_rise or event_fall.
- Config error: while cfg_err=1, valid samples are ignored; state, cnt and statistics are frozen.
- Disable: cfg_enable=0 forces state LOW, cnt=0 and level_high=0 on the next edge, with no event pulses. Re-enable resumes from LOW.
- Arithmetic: all comparisons are unsigned, full DATA_WIDTH; no rounding.

## Timing
- Reset value of all outputs is 0; state is LOW.
- Latency: level_high, event_rise/event_fall, event_data, peak_value and dwell_len update on the clock edge after the completing valid sample. That is one cycle of latency, with no combinational input→output path.
- Event pulses last exactly one cycle, even if the next cycle carries another valid sample.
- Back-to-back transitions: a fall completing on sample k and a new rise opening on sample k+1 are both legal. The new episode starts from k+1.
- cfg_err is registered one cycle after a threshold change. Thresholds are sampled every cycle; a change mid-debounce applies to the next valid sample.
- rst overrides cfg_enable and any in-flight debounce.

## Structure
- Shared package sma_pkg: state enum typedef sma_lvl_state_t (LOW, RISE_PEND, HIGH, FALL_PEND) and a saturating-increment function reused by counters.
- Sub-module sma_episode_stats: peak/dwell tracker with open/update/discard/close controls, instantiated once. The FSM and debounce stay in the top level.

## Test plan
Defaults for all scenarios: DEBOUNCE_N=4, hi=1000, lo=800.
- Reset asserted mid-episode → all outputs 0 the next cycle; state LOW.
- Samples 1100, 1300, 1250, 1500 (valid, back-to-back) → event_rise and level_high=1 one cycle after 1500; event_data=1500.
- Samples 1200, 1200, 1200, 900, 1200 → no event_rise; level_high stays 0.
- Full episode: 1100, 1300, 1250, 1500, 1400, 700, 700, 700, 700 → event_fall one cycle after the last 700; peak_value=1500, dwell_len=9, event_data=700.
- Same episode with 0–3 random idle cycles between valid samples → identical outputs; event timing is relative to the completing sample. In HIGH, drop cfg_enable → level_high=0 next cycle with no event_fall.
- Set lo=1000, hi=1000 → cfg_err=1 next cycle. Then feed samples 2000 ×4 → no state change.
